jump_ctrl: RTL

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jump_ctrl.sv
// Dino jump controller: button edge detect, tick divider and a
// GROUND/RISE/HANG/FALL height trajectory with registered outputs.
module jump_ctrl #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int JUMP_H     = 60,
    parameter int RISE_STEP  = 6,
    parameter int FALL_STEP  = 6,
    parameter int HANG_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_level,
    input  logic       game_run,
    output logic [7:0] dino_y,
    output logic       airborne,
    output logic       jump_start,
    output logic       land
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        HANG,
        FALL
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      y_q, y_d;
    logic            air_q, air_d;
    logic            js_q, js_d;
    logic            land_q, land_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hang_q, hang_d;
    logic            prev_q;

    logic            press;
    logic            tick;
    logic [8:0]      rise_sum;

    assign press    = btn_level & ~prev_q;
    assign tick     = (cnt_q == CW'(TICK_DIV - 1));
    assign rise_sum = {1'b0, y_q} + 9'(RISE_STEP);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        hang_d  = hang_q;
        js_d    = 1'b0;
        land_d  = 1'b0;
        if (game_run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                GROUND: begin
                    y_d = 8'd0;
                    // the land cycle itself never accepts a press
                    if (press && !land_q) begin
                        state_d = RISE;
                        cnt_d   = '0;
                        hang_d  = 8'd0;
                        js_d    = 1'b1;
                    end
                end
                RISE: begin
                    if (tick) begin
                        if (rise_sum >= 9'(JUMP_H)) begin
                            y_d     = 8'(JUMP_H);
                            state_d = HANG;
                            hang_d  = 8'd0;
                        end else begin
                            y_d = rise_sum[7:0];
                        end
                    end
                end
                HANG: begin
                    if (tick) begin
                        if (hang_q == 8'(HANG_TICKS - 1)) begin
                            state_d = FALL;
                            hang_d  = 8'd0;
                        end else begin
                            hang_d = hang_q + 8'd1;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        if (y_q <= 8'(FALL_STEP)) begin
                            y_d     = 8'd0;
                            state_d = GROUND;
                            land_d  = 1'b1;
                        end else begin
                            y_d = y_q - 8'(FALL_STEP);
                        end
                    end
                end
                default: state_d = GROUND;
            endcase
        end
        air_d = (state_d != GROUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GROUND;
            y_q     <= 8'd0;
            air_q   <= 1'b0;
            js_q    <= 1'b0;
            land_q  <= 1'b0;
            cnt_q   <= '0;
            hang_q  <= 8'd0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            air_q   <= air_d;
            js_q    <= js_d;
            land_q  <= land_d;
            cnt_q   <= cnt_d;
            hang_q  <= hang_d;
            prev_q  <= btn_level;
        end
    end

    assign dino_y     = y_q;
    assign airborne   = air_q;
    assign jump_start = js_q;
    assign land       = land_q;

endmodule
